vga_char_feeder: RTL and testbench

- Sits directly upstream of the vga block.
- Accepts display writes (character or control) from the CPU/PIA side into a small FIFO and reports busy back to the CPU.
- Replays queued entries onto the vga write port (address/w_en/din) one at a time, throttled by a programmable inter-character gap.
- The gap emulates Apple-1 terminal pacing, and the FIFO absorbs CPU bursts.

---
 rtl/vga_char_feeder.sv | 138 +++++++++++++
 tb/tb_vga_char_feeder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_char_feeder.sv
// CPU-to-VGA display feeder: queues character/control writes in a FIFO and replays
// them onto the vga write port with a programmable gap. Optional macro VGA_FEEDER_UPCASE_EN.
module vga_char_feeder #(
   parameter int FIFO_DEPTH = 16,
   parameter int GAP_CYCLES = 4
) (
   input  logic       clk25,
   input  logic       rst,
   input  logic       enable,
   input  logic       cpu_we,
   input  logic       cpu_addr,
   input  logic [7:0] cpu_din,
   output logic       dsp_busy,
   output logic       dsp_empty,
   output logic       address,
   output logic       w_en,
   output logic [7:0] din,
   output logic       overflow,
   output logic       dbg_state_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic {S_IDLE = 1'b0, S_GAP = 1'b1} state_t;

   // Handshake: cpu_we is a one-cycle strobe accepted whenever the FIFO is not full;
   // w_en is a one-cycle strobe the vga side must take unconditionally.

   state_t          state_q, state_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [8:0]      mem_q [FIFO_DEPTH];
   logic            addr_q, addr_d;
   logic [7:0]      din_q, din_d;
   logic            w_en_q, w_en_d;
   logic            busy_q, empty_q, overflow_q;
   logic            full, fifo_empty, push, pop;
   logic [6:0]      char7;
   logic [8:0]      push_entry;

   assign full       = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = cpu_we && !full;

   always_comb begin
      char7 = cpu_din[6:0];
`ifdef VGA_FEEDER_UPCASE_EN
      if (char7 >= 7'h61 && char7 <= 7'h7A) char7 = char7 - 7'h20;
`endif
      push_entry = cpu_addr ? {1'b1, cpu_din} : {2'b00, char7};
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      w_en_d  = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  pop             = 1'b1;
                  {addr_d, din_d} = mem_q[rd_ptr_q];
                  w_en_d          = 1'b1;
                  gap_d           = GW'(GAP_CYCLES);
                  state_d         = S_GAP;
               end
            end
            S_GAP: begin
               if (gap_q <= GW'(1)) begin
                  gap_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  gap_d = gap_q - GW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk25) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gap_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         addr_q     <= 1'b0;
         din_q      <= 8'h00;
         w_en_q     <= 1'b0;
         busy_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         w_en_q     <= w_en_d;
         busy_q     <= (count_d == CW'(FIFO_DEPTH));
         empty_q    <= (count_d == '0) && (state_d == S_IDLE);
         overflow_q <= overflow_q | (cpu_we && full);
      end
   end

   assign dsp_busy    = busy_q;
   assign dsp_empty   = empty_q;
   assign address     = addr_q;
   assign din         = din_q;
   assign w_en        = w_en_q;
   assign overflow    = overflow_q;
   assign dbg_state_o = (state_q == S_GAP);

endmodule

// File: tb/tb_vga_char_feeder.sv
// Directed bench for vga_char_feeder: pacing, ordering, overflow, enable stall,
// reset flush and optional upper-casing.
module tb_vga_char_feeder;

   logic       clk25 = 1'b0;
   logic       rst, enable, cpu_we, cpu_addr;
   logic [7:0] cpu_din;
   logic       dsp_busy, dsp_empty, address, w_en, overflow, dbg_state;
   logic [7:0] din;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [8:0] got_q [$];
   int         cyc_q [$];
   logic [7:0] up_exp_a, up_exp_b;

   vga_char_feeder #(.FIFO_DEPTH(16), .GAP_CYCLES(4)) dut (
      .clk25(clk25), .rst(rst), .enable(enable), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .dsp_busy(dsp_busy),
      .dsp_empty(dsp_empty), .address(address), .w_en(w_en), .din(din),
      .overflow(overflow), .dbg_state_o(dbg_state)
   );

   always #5 clk25 = ~clk25;

   always @(posedge clk25) cyc <= cyc + 1;

   // Capture every vga write with the cycle it appeared in.
   always @(negedge clk25) begin
      if (w_en) begin
         got_q.push_back({address, din});
         cyc_q.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk25);
      #1;
   endtask

   task automatic write(input logic a, input logic [7:0] d);
      cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
      tick();
      cpu_we = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef VGA_FEEDER_UPCASE_EN
      up_exp_a = 8'h41; up_exp_b = 8'h5A;
`else
      up_exp_a = 8'h61; up_exp_b = 8'h7A;
`endif
      rst = 1'b1; enable = 1'b1; cpu_we = 1'b0; cpu_addr = 1'b0; cpu_din = 8'h00;
      repeat (3) tick();
      check("rst_busy", dsp_busy, 0);
      check("rst_empty", dsp_empty, 1);
      check("rst_address", address, 0);
      check("rst_w_en", w_en, 0);
      check("rst_din", din, 8'h00);
      check("rst_overflow", overflow, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Single char: bit 7 stripped, one-cycle latency, empty after gap
      write(1'b0, 8'hC1);
      check("c1_w_en_push", w_en, 0);
      check("c1_empty_push", dsp_empty, 0);
      tick();
      check("c1_w_en", w_en, 1);
      check("c1_address", address, 0);
      check("c1_din", din, 8'h41);
      tick();
      check("c1_w_en_drop", w_en, 0);
      check("c1_din_hold", din, 8'h41);
      repeat (2) tick();
      check("c1_empty_p4", dsp_empty, 0);
      tick();
      check("c1_empty_p5", dsp_empty, 1);
      repeat (3) tick();

      // Control entry between two chars keeps bit 7
      got_q.delete(); cyc_q.delete();
      write(1'b0, 8'h41);
      write(1'b1, 8'h80);
      write(1'b0, 8'h42);
      repeat (25) tick();
      check("ctl_count", got_q.size(), 3);
      check("ctl_e0", got_q[0], 9'h041);
      check("ctl_e1", got_q[1], 9'h180);
      check("ctl_e2", got_q[2], 9'h042);
      check("ctl_gap01", cyc_q[1] - cyc_q[0], 5);
      check("ctl_gap12", cyc_q[2] - cyc_q[1], 5);

      // Lower-case handling and control passthrough
      got_q.delete(); cyc_q.delete();
      write(1'b0, 8'h61);
      write(1'b0, 8'hFA);
      write(1'b1, 8'h61);
      repeat (25) tick();
      check("up_count", got_q.size(), 3);
      check("up_a", got_q[0], {1'b0, up_exp_a});
      check("up_z", got_q[1], {1'b0, up_exp_b});
      check("up_ctl", got_q[2], 9'h161);

      // Burst of 22: last two rejected, the 22nd coincides with a pop while full
      got_q.delete(); cyc_q.delete();
      for (int i = 0; i < 22; i++) begin
         cpu_we = 1'b1; cpu_addr = 1'b0; cpu_din = 8'(8'h20 + i);
         tick();
         if (i == 18) begin
            check("burst_busy_18", dsp_busy, 0);
            check("burst_ovf_18", overflow, 0);
         end
         if (i == 19) begin
            check("burst_busy_19", dsp_busy, 1);
            check("burst_ovf_19", overflow, 0);
         end
         if (i == 20) begin
            check("burst_busy_20", dsp_busy, 1);
            check("burst_ovf_20", overflow, 1);
         end
         if (i == 21) begin
            check("burst_busy_21", dsp_busy, 0);
            check("burst_ovf_21", overflow, 1);
         end
      end
      cpu_we = 1'b0;
      repeat (100) tick();
      check("burst_count", got_q.size(), 20);
      for (int i = 0; i < 20; i++) begin
         check($sformatf("burst_e%0d", i), got_q[i], 9'(9'h020 + i));
         if (i > 0) check($sformatf("burst_gap%0d", i), cyc_q[i] - cyc_q[i-1], 5);
      end
      check("burst_empty_end", dsp_empty, 1);
      check("burst_ovf_sticky", overflow, 1);

      // Enable low for 10 cycles inside a gap, with a push during the stall
      got_q.delete(); cyc_q.delete();
      write(1'b0, 8'h50);
      write(1'b0, 8'h51);
      tick();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 2) write(1'b0, 8'h52);
         else tick();
      end
      check("stall_pulses", got_q.size(), 1);
      check("stall_state", dbg_state, 1);
      check("stall_w_en", w_en, 0);
      enable = 1'b1;
      repeat (30) tick();
      check("stall_count", got_q.size(), 3);
      check("stall_e0", got_q[0], 9'h050);
      check("stall_e1", got_q[1], 9'h051);
      check("stall_e2", got_q[2], 9'h052);
      check("stall_gap01", cyc_q[1] - cyc_q[0], 15);
      check("stall_gap12", cyc_q[2] - cyc_q[1], 5);

      // Reset with 5 entries queued flushes everything
      enable = 1'b0;
      for (int i = 0; i < 5; i++) write(1'b0, 8'(8'h30 + i));
      check("flush_pre_empty", dsp_empty, 0);
      check("flush_pre_busy", dsp_busy, 0);
      rst = 1'b1; enable = 1'b1;
      tick();
      check("flush_w_en", w_en, 0);
      check("flush_empty", dsp_empty, 1);
      check("flush_overflow", overflow, 0);
      check("flush_address", address, 0);
      check("flush_din", din, 8'h00);
      rst = 1'b0;
      got_q.delete(); cyc_q.delete();
      repeat (10) tick();
      check("flush_no_pulses", got_q.size(), 0);
      check("flush_empty_after", dsp_empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
